serializer_8b: RTL and testbench

Parallel-to-serial transmitter; the transmit-side counterpart of the deserializer. Accepts parallel words over a valid/ready handshake and shifts them onto a single serial line, one bit per `clk`. Contains a shift register plus a one-entry holding buffer, so back-to-back words leave as a continuous bit stream with no gap. Sits between the parallel source (test sequencer or upstream FIFO read side) and the serial link that feeds the deserializer's `in_data`.

---
 rtl/serializer_8b.sv | 115 +++++++++++
 tb/tb_serializer_8b.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_8b.sv
// serializer_8b: parallel-to-serial transmitter with a one-entry holding buffer.
// Words arrive over a valid/ready handshake and leave one bit per clock. A word
// accepted while another is shifting waits in the holding buffer, so consecutive
// words form a continuous bit stream with no idle cycle between them.
module serializer_8b #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_8b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_data,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic             holdValid_q, holdValid_d;

  logic             accept;
  logic             lastBit;
  logic [WIDTH-1:0] shifted;

  // Ready only depends on the holding buffer being free; reset blocks any accept.
  assign in_ready = !holdValid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign lastBit  = (bitCnt_q == LAST);

  // Shift register moves one position toward its output end, filling with idle level.
  always_comb begin
    shifted = sr_q;
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], IDLE_BIT};
    end else begin
      shifted = {IDLE_BIT, sr_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: decide where an accepted word goes and when a word reloads.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    bitCnt_d    = bitCnt_q;
    holdValid_d = holdValid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d     = in_8b;
          bitCnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sr_d     = shifted;
        bitCnt_d = bitCnt_q + CW'(1);
        if (lastBit) begin
          bitCnt_d = '0;
          if (holdValid_q) begin
            sr_d        = hold_q;
            holdValid_d = 1'b0;
          end else if (accept) begin
            sr_d = in_8b;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          hold_d      = in_8b;
          holdValid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset discarding any in-flight or held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= {WIDTH{IDLE_BIT}};
      hold_q      <= '0;
      bitCnt_q    <= '0;
      holdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      bitCnt_q    <= bitCnt_d;
      holdValid_q <= holdValid_d;
    end
  end

  assign out_valid   = (state_q == SHIFT);
  assign out_data    = out_valid ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_BIT;
  assign frame_start = out_valid && (bitCnt_q == '0);
  assign busy        = out_valid || holdValid_q;

endmodule

// File: tb/tb_serializer_8b.sv
// Testbench for serializer_8b: two instances (MSB-first/idle-0 and LSB-first/idle-1)
// share one stimulus stream and are compared every cycle against a queue-of-bits model.
module tb_serializer_8b;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inData;
  logic       inValid;

  logic mainReady, mainData, mainValid, mainFs, mainBusy;
  logic altReady, altData, altValid, altFs, altBusy;

  serializer_8b #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutMain (
    .clk(clk), .reset(reset), .in_8b(inData), .in_valid(inValid),
    .in_ready(mainReady), .out_data(mainData), .out_valid(mainValid),
    .frame_start(mainFs), .busy(mainBusy)
  );

  serializer_8b #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutAlt (
    .clk(clk), .reset(reset), .in_8b(inData), .in_valid(inValid),
    .in_ready(altReady), .out_data(altData), .out_valid(altValid),
    .frame_start(altFs), .busy(altBusy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Model: every bit still to appear on the line, tagged with a first-of-word flag.
  bit [1:0] qMain[$];
  bit [1:0] qAlt[$];
  bit       primed = 1'b0;
  int       checkCount = 0;
  int       passCount = 0;
  int       cycleNo = 0;

  logic obsMainData, obsMainValid, obsMainFs, obsMainReady, obsMainBusy;
  logic obsAltData, obsAltValid, obsAltFs, obsAltBusy;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       eData;
    logic       eValid;
    logic       eFs;
    logic       eReady;
  } vec_t;

  vec_t tbl[10];

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleNo, got, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs that were applied.
  task automatic modelEdge();
    logic acc;
    acc = inValid && !reset && (qMain.size() <= 8);
    if (reset) begin
      qMain.delete();
      qAlt.delete();
      primed = 1'b1;
    end else begin
      if (qMain.size() > 0) void'(qMain.pop_front());
      if (qAlt.size() > 0) void'(qAlt.pop_front());
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          qMain.push_back({(i == 0), inData[7-i]});
          qAlt.push_back({(i == 0), inData[i]});
        end
      end
    end
  endtask

  // Drive one cycle of inputs, sample and check both DUTs, then cross the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    logic expReady;
    @(negedge clk);
    reset   = r;
    inValid = v;
    inData  = d;
    #1;
    obsMainData  = mainData;
    obsMainValid = mainValid;
    obsMainFs    = mainFs;
    obsMainReady = mainReady;
    obsMainBusy  = mainBusy;
    obsAltData   = altData;
    obsAltValid  = altValid;
    obsAltFs     = altFs;
    obsAltBusy   = altBusy;
    if (primed) begin
      expReady = !r && (qMain.size() <= 8);
      checkOutput("main.in_ready", {15'd0, mainReady}, {15'd0, expReady});
      checkOutput("main.out_valid", {15'd0, mainValid}, {15'd0, qMain.size() > 0});
      checkOutput("main.out_data", {15'd0, mainData},
                  {15'd0, (qMain.size() > 0) ? qMain[0][0] : 1'b0});
      checkOutput("main.frame_start", {15'd0, mainFs},
                  {15'd0, (qMain.size() > 0) && qMain[0][1]});
      checkOutput("main.busy", {15'd0, mainBusy}, {15'd0, qMain.size() > 0});
      checkOutput("alt.in_ready", {15'd0, altReady}, {15'd0, expReady});
      checkOutput("alt.out_valid", {15'd0, altValid}, {15'd0, qAlt.size() > 0});
      checkOutput("alt.out_data", {15'd0, altData},
                  {15'd0, (qAlt.size() > 0) ? qAlt[0][0] : 1'b1});
      checkOutput("alt.frame_start", {15'd0, altFs},
                  {15'd0, (qAlt.size() > 0) && qAlt[0][1]});
      checkOutput("alt.busy", {15'd0, altBusy}, {15'd0, qAlt.size() > 0});
    end
    @(posedge clk);
    modelEdge();
    cycleNo++;
  endtask

  // Main test sequence: table, directed corner cases, then randomized traffic.
  initial begin
    logic [15:0] stream, fsMask, readyMask;
    logic [7:0]  mainV, altV;
    int          validCount, lateValid;
    logic        v, r, holdPending, readyNow;
    logic [7:0]  d;

    reset   = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h55);
    checkOutput("reset.in_ready", {15'd0, obsMainReady}, 16'd0);
    checkOutput("reset.out_valid", {15'd0, obsMainValid}, 16'd0);
    checkOutput("reset.busy", {15'd0, obsMainBusy}, 16'd0);

    // Single word 0xA5 from idle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, tbl[i].v, tbl[i].d);
      checkOutput("tbl.out_data", {15'd0, obsMainData}, {15'd0, tbl[i].eData});
      checkOutput("tbl.out_valid", {15'd0, obsMainValid}, {15'd0, tbl[i].eValid});
      checkOutput("tbl.frame_start", {15'd0, obsMainFs}, {15'd0, tbl[i].eFs});
      checkOutput("tbl.in_ready", {15'd0, obsMainReady}, {15'd0, tbl[i].eReady});
    end

    // Back-to-back 0x3C then 0xC3 with valid held until the hold slot is taken.
    applyStimulus(1'b0, 1'b1, 8'h3C);
    stream = '0; fsMask = '0; readyMask = '0; validCount = 0;
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b0, (k <= 7), 8'hC3);
      if (k < 16) begin
        stream    = {stream[14:0], obsMainData};
        fsMask    = {fsMask[14:0], obsMainFs};
        readyMask = {readyMask[14:0], obsMainReady};
        if (obsMainValid) validCount++;
      end else begin
        checkOutput("b2b.tail_valid", {15'd0, obsMainValid}, 16'd0);
      end
    end
    checkOutput("b2b.stream", stream, 16'h3CC3);
    checkOutput("b2b.frame_start", fsMask, 16'h8080);
    checkOutput("b2b.in_ready", readyMask, 16'h80FF);
    checkOutput("b2b.valid_cycles", 16'(validCount), 16'd16);

    // Word 0x01 on both bit orders; idle level afterwards.
    applyStimulus(1'b0, 1'b1, 8'h01);
    mainV = '0; altV = '0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (k < 8) begin
        mainV    = {mainV[6:0], obsMainData};
        altV[k]  = obsAltData;
      end else begin
        checkOutput("idle1.out_data", {15'd0, obsAltData}, 16'd1);
        checkOutput("idle1.out_valid", {15'd0, obsAltValid}, 16'd0);
      end
    end
    checkOutput("msb.word01", {8'd0, mainV}, 16'h0001);
    checkOutput("lsb.word01", {8'd0, altV}, 16'h0001);

    // 0xFF presented exactly on the last bit of 0x00.
    applyStimulus(1'b0, 1'b1, 8'h00);
    stream = '0; validCount = 0;
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b0, (k == 7), 8'hFF);
      if (k < 16) begin
        stream = {stream[14:0], obsMainData};
        if (obsMainValid) validCount++;
      end
    end
    checkOutput("lastbit.stream", stream, 16'h00FF);
    checkOutput("lastbit.valid_cycles", 16'(validCount), 16'd16);

    // Reset during bit 4 of 0xF0 with 0x0F held; then a fresh 0x81.
    applyStimulus(1'b0, 1'b1, 8'hF0);
    applyStimulus(1'b0, 1'b1, 8'h0F);
    checkOutput("rst.held", {15'd0, obsMainBusy}, 16'd1);
    for (int k = 1; k < 4; k++) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst.out_valid", {15'd0, obsMainValid}, 16'd0);
    checkOutput("rst.busy", {15'd0, obsMainBusy}, 16'd0);
    checkOutput("rst.out_data", {15'd0, obsMainData}, 16'd0);
    checkOutput("rst.alt_out_data", {15'd0, obsAltData}, 16'd1);
    lateValid = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (obsMainValid || obsMainBusy || obsAltValid) lateValid++;
    end
    checkOutput("rst.no_resume", 16'(lateValid), 16'd0);
    applyStimulus(1'b0, 1'b1, 8'h81);
    mainV = '0; altV = '0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      mainV   = {mainV[6:0], obsMainData};
      altV[k] = obsAltData;
    end
    checkOutput("rst.msb_word81", {8'd0, mainV}, 16'h0081);
    checkOutput("rst.lsb_word81", {8'd0, altV}, 16'h0081);

    // Randomized traffic with gaps, bursts and occasional resets.
    holdPending = 1'b0;
    d = 8'h00;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) == 0);
      if (holdPending) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 99) < 45);
        d = 8'($urandom);
      end
      readyNow    = !r && (qMain.size() <= 8);
      holdPending = v && !readyNow;
      applyStimulus(r, v, d);
    end
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
